// File: rtl/sc_phase_accumulator_if.sv
// rtl/sc_phase_accumulator_if.sv - result valid/ready channel of the phase accumulator
// The producer drives result/result_valid; the consumer drives result_ready.
interface sc_phase_accumulator_if #(
  parameter int N_COL = 32,
  parameter int CNT_W = 6
) ();
  logic [N_COL*CNT_W-1:0] result;
  logic                   result_valid;
  logic                   result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/sc_phase_accumulator.sv
// rtl/sc_phase_accumulator.sv - stochastic-compute phase sequencer and signed bitline accumulator
// Runs POS then NEG compute phases, counting sensed bitline ones up then down per column.
module sc_phase_accumulator #(
  parameter int N_COL   = 32,
  parameter int SEQ_LEN = 31,
  parameter int CNT_W   = 6
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   dense_en,
  input  logic [N_COL-1:0]       sc_bl,
  output logic                   compute_en,
  output logic                   comp_positive_phase,
  output logic                   read_en,
  output logic                   dense_en_q,
  output logic                   busy,
  sc_phase_accumulator_if.master res_if
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POS   = 3'd1;
  localparam logic [2:0] S_NEG   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              PC_W          = $clog2(SEQ_LEN + 1);
  localparam logic [PC_W-1:0] PC_ONE        = PC_W'(1);
  localparam logic [PC_W-1:0] PC_LAST_DENSE = PC_W'(SEQ_LEN - 1);

  logic [2:0]              state_q, state_d;
  logic [PC_W-1:0]         phase_cnt_q, phase_cnt_d;
  logic [PC_W-1:0]         phase_last;
  logic                    dense_latch_q, dense_latch_d;
  logic                    valid_q, valid_d;
  logic                    ce_dly_q, ph_dly_q;
  logic                    clear_acc;
  logic signed [CNT_W-1:0] acc_q [N_COL];
  logic signed [CNT_W-1:0] acc_d [N_COL];
  logic [N_COL*CNT_W-1:0]  result_flat;

  assign phase_last = dense_latch_q ? PC_LAST_DENSE : '0;

  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    dense_latch_d = dense_latch_q;
    valid_d       = valid_q;
    clear_acc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dense_latch_d = dense_en;
          phase_cnt_d   = '0;
          clear_acc     = 1'b1;
          state_d       = S_POS;
        end
      end
      S_POS: begin
        if (phase_cnt_q == phase_last) begin
          phase_cnt_d = '0;
          state_d     = S_NEG;
        end else begin
          phase_cnt_d = phase_cnt_q + PC_ONE;
        end
      end
      S_NEG: begin
        if (phase_cnt_q == phase_last) begin
          phase_cnt_d = '0;
          state_d     = S_DRAIN;
        end else begin
          phase_cnt_d = phase_cnt_q + PC_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // The final negative sample lands on entry to DONE; valid follows one edge later.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (res_if.result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    for (int c = 0; c < N_COL; c++) begin
      acc_d[c] = acc_q[c];
      if (clear_acc) begin
        acc_d[c] = '0;
      end else if (ce_dly_q) begin
        if (ph_dly_q) begin
          acc_d[c] = acc_q[c] + {{(CNT_W-1){1'b0}}, sc_bl[c]};
        end else begin
          acc_d[c] = acc_q[c] - {{(CNT_W-1){1'b0}}, sc_bl[c]};
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      phase_cnt_q   <= '0;
      dense_latch_q <= 1'b0;
      valid_q       <= 1'b0;
      ce_dly_q      <= 1'b0;
      ph_dly_q      <= 1'b0;
      for (int c = 0; c < N_COL; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      dense_latch_q <= dense_latch_d;
      valid_q       <= valid_d;
      // sc_bl trails compute_en by one cycle, so the sampling qualifiers are delayed to match.
      ce_dly_q      <= compute_en;
      ph_dly_q      <= comp_positive_phase;
      for (int c = 0; c < N_COL; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  always_comb begin
    result_flat = '0;
    for (int c = 0; c < N_COL; c++) begin
      result_flat[c*CNT_W +: CNT_W] = acc_q[c];
    end
  end

  assign compute_en          = (state_q == S_POS) || (state_q == S_NEG);
  assign comp_positive_phase = (state_q == S_POS);
  assign read_en             = 1'b0;
  assign dense_en_q          = dense_latch_q;
  assign busy                = (state_q != S_IDLE);

  assign res_if.result       = result_flat;
  assign res_if.result_valid = valid_q;

endmodule

// File: doc/sc_phase_accumulator.md
Name: sc_phase_accumulator

Overview:
- Sequences one stochastic-compute evaluation for the input SNG bank and reduces the crossbar's per-column bitline bits into signed column results.
- Drives compute_en and comp_positive_phase to the SNG bank, and holds read_en low.
- Counts sensed bitline ones up during the positive phase and down during the negative phase.
- Presents the signed per-column counts on a valid/ready output.
- Sits directly downstream of the SNG bank/crossbar column sense path.

Parameters:
- N_COL, 32, number of bitline columns accumulated.
- SEQ_LEN, 31, compute cycles per phase in dense mode (LFSR period for 5-bit LFSR).
- CNT_W, 6, signed two's-complement width per column result; must satisfy 2^(CNT_W-1) > SEQ_LEN.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin an evaluation; sampled only in IDLE.
- dense_en  in  1  mode for this evaluation, latched on accepted start; also forwarded to SNG bank.
- sc_bl  in  N_COL  sensed bitline bits; valid one cycle after the compute cycle that produced them.
- compute_en  out  1  enables SNG/LFSR stepping.
- comp_positive_phase  out  1  1 = positive phase, 0 = negative phase.
- read_en  out  1  constant 0 (compute path only).
- dense_en_q  out  1  latched dense_en, driven to the SNG bank.
- busy  out  1  high in any state other than IDLE.
- result  out  N_COL*CNT_W  column c in bits [c*CNT_W +: CNT_W], signed.
- result_valid  out  1  result is stable and valid.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset values: all outputs 0, all counters 0, state IDLE. Reset is asynchronous and can occur in any state; it aborts the evaluation and no result is produced.
- Phase length: PLEN = SEQ_LEN when dense_en_q=1, PLEN = 1 when dense_en_q=0.
- States and transitions:
  - IDLE: start=1 latches dense_en into dense_en_q, clears all column accumulators and the phase counter, then moves to POS.
  - POS: compute_en=1, comp_positive_phase=1 for exactly PLEN cycles, then NEG.
  - NEG: compute_en=1, comp_positive_phase=0 for exactly PLEN cycles, then DRAIN.
  - DRAIN: one cycle with compute_en=0; comp_positive_phase holds 0. Then DONE.
  - DONE: result_valid=1, result held stable. result_valid & result_ready moves to IDLE on the next edge, where result_valid=0.
- Sampling pipeline: the registers ce_d and ph_d are the 1-cycle-delayed copies of compute_en and comp_positive_phase.
  - When ce_d=1, each column c updates acc[c] += sc_bl[c] if ph_d=1, or acc[c] -= sc_bl[c] if ph_d=0.
  - The last negative-phase sample is taken in DRAIN.
- Arithmetic: plain CNT_W-bit two's complement. Overflow is impossible under the parameter constraint, so there is no saturation logic.
- Result range: acc[c] ends in [-PLEN, +PLEN].
- Latency: start accepted at edge 0 gives result_valid high from edge 2*PLEN+2. That is 64 cycles for dense with SEQ_LEN=31, and 4 cycles for non-dense.
- start handling:
  - start outside IDLE is ignored, including in DONE and in the handshake cycle.
  - start must be re-asserted once back in IDLE.
  - start and reset in the same cycle: reset wins.
- result_ready while result_valid=0 has no effect.
- result persists unchanged in IDLE until the next accepted start clears it.
- read_en is tied 0 in every state.

Test Plan:
- Reset mid-NEG (dense, cycle 40) -> all outputs 0 immediately (asynchronous). After release, no result_valid until a new start.
- Dense, sc_bl all ones during POS, all zeros during NEG, result_ready=1 -> result_valid at cycle 64, every column = +31 (6'b011111). Returns to IDLE next cycle.
- Dense, column 0 all ones in both phases, column 1 ones only in NEG, column 2 alternating 1/0 in POS, others 0 -> col0=0, col1=-31, col2=+16, others 0. Checks the 1-cycle sample alignment at POS→NEG and at DRAIN.
- Non-dense, sc_bl[5]=1 in POS sample only -> compute_en high for exactly 2 cycles, result_valid at cycle 4, col5=+1, all others 0.
- Backpressure: result_ready=0 for 10 cycles in DONE with start pulsed there -> result_valid and result stable. start is ignored, busy stays 1, and IDLE is entered the cycle after ready rises.
- Check read_en=0 and dense_en_q stable across a whole evaluation when the dense_en input toggles after start.
